// File: rtl/pixel_write_port.sv
//==============================================================================
// Module      : pixel_write_port
// Description : Buffered pixel sink that read-modify-writes a 1-bpp packed
//               framebuffer, with a one-word cache and clipping counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pixel_write_port #(
   parameter int unsigned WIDTH      = 640,
   parameter int unsigned HEIGHT     = 480,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned ADDR_W     = 15
) (
   input  logic              CLOCK_50,
   input  logic              nReset,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic [10:0]       pix_x,
   input  logic [10:0]       pix_y,
   input  logic              pix_colour,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_rvalid,
   output logic              mem_wr,
   output logic [15:0]       mem_wdata,
   input  logic              mem_wack,
   output logic              busy,
   output logic [15:0]       clip_count
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LIN_W = ADDR_W + 4;
   localparam int unsigned ENT_W = LIN_W + 1;
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WAIT  = 3'd2,
      S_MERGE = 3'd3,
      S_WRITE = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic [ENT_W-1:0]  fifo_mem_q [FIFO_DEPTH];
   logic [3:0]        bit_q, bit_d;
   logic              colour_q, colour_d;
   logic              cache_valid_q, cache_valid_d;
   logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
   logic [15:0]       cache_data_q, cache_data_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [15:0]       mem_wdata_q, mem_wdata_d;
   logic [15:0]       clip_count_q, clip_count_d;

   logic [LIN_W-1:0]  lin;
   logic [ENT_W-1:0]  head;
   logic              clipped, handshake, push, pop;

   // Linear pixel index truncated to word+bit; low nibble equals x[3:0]
   // because WIDTH is a multiple of 16.
   always_comb begin
      lin       = LIN_W'(32'(pix_y) * WIDTH + 32'(pix_x));
      clipped   = (32'(pix_x) >= WIDTH) || (32'(pix_y) >= HEIGHT);
      handshake = pix_valid && pix_ready;
      push      = handshake && !clipped;
      head      = fifo_mem_q[rd_ptr_q];
   end

   always_comb begin
      wr_ptr_d     = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d     = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d      = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
         count_d = count_q - CNT_ONE;
      end
      clip_count_d = clip_count_q;
      if (handshake && clipped && (clip_count_q != 16'hFFFF)) begin
         clip_count_d = clip_count_q + 16'd1;
      end
   end

   always_comb begin
      state_d       = state_q;
      bit_d         = bit_q;
      colour_d      = colour_q;
      cache_valid_d = cache_valid_q;
      cache_addr_d  = cache_addr_q;
      cache_data_d  = cache_data_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      pop           = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop        = 1'b1;
               mem_addr_d = head[LIN_W-1:4];
               bit_d      = head[3:0];
               colour_d   = head[ENT_W-1];
               if (cache_valid_q && (cache_addr_q == head[LIN_W-1:4])) begin
                  state_d = S_MERGE;
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_READ: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               cache_data_d  = mem_rdata;
               cache_addr_d  = mem_addr_q;
               cache_valid_d = 1'b1;
               state_d       = S_MERGE;
            end
         end
         S_MERGE: begin
            cache_data_d[bit_q] = colour_q;
            mem_wdata_d         = cache_data_d;
            state_d             = S_WRITE;
         end
         S_WRITE: begin
            if (mem_wack) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge nReset) begin
      if (!nReset) begin
         state_q       <= S_IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         bit_q         <= '0;
         colour_q      <= 1'b0;
         cache_valid_q <= 1'b0;
         cache_addr_q  <= '0;
         cache_data_q  <= '0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         clip_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         bit_q         <= bit_d;
         colour_q      <= colour_d;
         cache_valid_q <= cache_valid_d;
         cache_addr_q  <= cache_addr_d;
         cache_data_q  <= cache_data_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         clip_count_q  <= clip_count_d;
      end
   end

   // Payload storage needs no reset; occupancy is tracked by count_q.
   always_ff @(posedge CLOCK_50) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= {pix_colour, lin};
      end
   end

   assign pix_ready  = (count_q != FULL_CNT);
   assign mem_rd     = (state_q == S_READ);
   assign mem_wr     = (state_q == S_WRITE);
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign busy       = (count_q != '0) || (state_q != S_IDLE);
   assign clip_count = clip_count_q;

endmodule

`default_nettype wire
